// File: rtl/comparator_bist_driver.sv
// Exhaustive sweep driver and response checker for a WIDTH-bit magnitude comparator (AgB/BgA/AeB).
// Optional first-failure capture ports are enabled by defining COMP_BIST_FIRST_FAIL_EN.
module comparator_bist_driver #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic             dut_agb,
    input  logic             dut_bga,
    input  logic             dut_aeb,
    output logic [ERR_W-1:0] err_count
`ifdef COMP_BIST_FIRST_FAIL_EN
    ,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
`endif
);

    localparam int CNT_W = 2 * WIDTH;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SET_W-1:0]   settle_r;
    logic               busy_r;
    logic               done_r;
    logic [ERR_W-1:0]   err_count_r;
    logic               mismatch_s;
    logic [ERR_W-1:0]   err_next_s;
`ifdef COMP_BIST_FIRST_FAIL_EN
    logic               fail_valid_r;
    logic [WIDTH-1:0]   fail_a_r;
    logic [WIDTH-1:0]   fail_b_r;
`endif

    // Operands come straight from the vector counter flops, so they are registered.
    assign dut_a     = cnt_r[CNT_W-1:WIDTH];
    assign dut_b     = cnt_r[WIDTH-1:0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_count = err_count_r;
    assign pass      = done_r && (err_count_r == {ERR_W{1'b0}});
`ifdef COMP_BIST_FIRST_FAIL_EN
    assign fail_valid = fail_valid_r;
    assign fail_a     = fail_a_r;
    assign fail_b     = fail_b_r;
`endif

    // Expected response and saturating error increment for the vector currently driven.
    always_comb begin
        mismatch_s = (dut_agb != (dut_a > dut_b)) ||
                     (dut_bga != (dut_b > dut_a)) ||
                     (dut_aeb != (dut_a == dut_b));
        if (err_count_r == ERR_MAX) begin
            err_next_s = err_count_r;
        end else begin
            err_next_s = err_count_r + ERR_W'(1);
        end
    end

    // Sweep sequencer: DRIVE holds each vector SETTLE cycles, SAMPLE checks it for one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            settle_r    <= {SET_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_count_r <= {ERR_W{1'b0}};
`ifdef COMP_BIST_FIRST_FAIL_EN
            fail_valid_r <= 1'b0;
            fail_a_r     <= {WIDTH{1'b0}};
            fail_b_r     <= {WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r     <= DRIVE;
                        cnt_r       <= {CNT_W{1'b0}};
                        settle_r    <= SETTLE_LOAD;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        err_count_r <= {ERR_W{1'b0}};
`ifdef COMP_BIST_FIRST_FAIL_EN
                        fail_valid_r <= 1'b0;
                        fail_a_r     <= {WIDTH{1'b0}};
                        fail_b_r     <= {WIDTH{1'b0}};
`endif
                    end
                end
                DRIVE: begin
                    if (settle_r == {SET_W{1'b0}}) begin
                        state_r <= SAMPLE;
                    end else begin
                        settle_r <= settle_r - SET_W'(1);
                    end
                end
                SAMPLE: begin
                    if (mismatch_s) begin
                        err_count_r <= err_next_s;
`ifdef COMP_BIST_FIRST_FAIL_EN
                        if (!fail_valid_r) begin
                            fail_valid_r <= 1'b1;
                            fail_a_r     <= dut_a;
                            fail_b_r     <= dut_b;
                        end
`endif
                    end
                    // The last vector ends the sweep without wrapping the counter.
                    if (&cnt_r) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r  <= DRIVE;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        settle_r <= SETTLE_LOAD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_bist_driver.sv
// Bench for comparator_bist_driver: two instances (SETTLE=1/ERR_W=16 and SETTLE=3/ERR_W=2) against a cycle-count model.
module tb_comparator_bist_driver;
    localparam int W = 2;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    int   mode0 = 0, mode1 = 0;

    logic busy0, done0, pass0, agb0, bga0, aeb0;
    logic busy1, done1, pass1, agb1, bga1, aeb1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [15:0] err0;
    logic [1:0]  err1;
`ifdef COMP_BIST_FIRST_FAIL_EN
    logic fv0, fv1;
    logic [W-1:0] fa0, fb0, fa1, fb1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Comparator under test: 0 ideal, 1 AeB stuck at 0, 2 AgB/BgA swapped.
    assign agb0 = (mode0 == 2) ? (b0 > a0) : (a0 > b0);
    assign bga0 = (mode0 == 2) ? (a0 > b0) : (b0 > a0);
    assign aeb0 = (mode0 == 1) ? 1'b0 : (a0 == b0);
    assign agb1 = (mode1 == 2) ? (b1 > a1) : (a1 > b1);
    assign bga1 = (mode1 == 2) ? (a1 > b1) : (b1 > a1);
    assign aeb1 = (mode1 == 1) ? 1'b0 : (a1 == b1);

    comparator_bist_driver #(.WIDTH(W), .SETTLE(1), .ERR_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .dut_a(a0), .dut_b(b0), .dut_agb(agb0), .dut_bga(bga0), .dut_aeb(aeb0),
        .err_count(err0)
`ifdef COMP_BIST_FIRST_FAIL_EN
        , .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0)
`endif
    );

    comparator_bist_driver #(.WIDTH(W), .SETTLE(3), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .dut_a(a1), .dut_b(b1), .dut_agb(agb1), .dut_bga(bga1), .dut_aeb(aeb1),
        .err_count(err1)
`ifdef COMP_BIST_FIRST_FAIL_EN
        , .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
`endif
    );

    // Model state: cycles since the accepting edge, plus the fault mode latched at start.
    int  mk[2];
    bit  mact[2];
    int  mmode[2];
    int  mS[2]   = '{1, 3};
    int  mMax[2] = '{65535, 3};

    function automatic bit faulty(input int m, input int idx);
        int a, b;
        a = idx / 4;
        b = idx % 4;
        if (m == 1) return (a == b);
        if (m == 2) return (a != b);
        return 1'b0;
    endfunction

    function automatic int sampled(input int d);
        int s;
        s = mk[d] / (mS[d] + 1);
        if (s > N) s = N;
        return s;
    endfunction

    function automatic int exp_err(input int d);
        int c;
        c = 0;
        for (int i = 0; i < sampled(d); i++) if (faulty(mmode[d], i)) c++;
        if (c > mMax[d]) c = mMax[d];
        return c;
    endfunction

    function automatic int first_fail(input int d);
        for (int i = 0; i < sampled(d); i++) if (faulty(mmode[d], i)) return i;
        return -1;
    endfunction

    function automatic bit m_idle(input int d);
        return !mact[d] || (mk[d] >= N * (mS[d] + 1));
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model advance on the DUT's active edge (and async reset).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                mact[d] = 1'b0;
                mk[d]   = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit st;
                st = (d == 0) ? start0 : start1;
                if (st && m_idle(d)) begin
                    mk[d]    = 0;
                    mact[d]  = 1'b1;
                    mmode[d] = (d == 0) ? mode0 : mode1;
                end else if (mact[d] && mk[d] < N * (mS[d] + 1)) begin
                    mk[d]++;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int eb, ed, ea, ebb, ee, ep, idx, ff;
            eb = 0; ed = 0; ea = 0; ebb = 0; ee = 0; idx = 0;
            if (mact[d]) begin
                if (mk[d] < N * (mS[d] + 1)) begin
                    eb  = 1;
                    idx = mk[d] / (mS[d] + 1);
                end else begin
                    ed  = 1;
                    idx = N - 1;
                end
                ea  = idx / 4;
                ebb = idx % 4;
                ee  = exp_err(d);
            end
            ep = (ed == 1 && ee == 0) ? 1 : 0;
            chk($sformatf("dut%0d busy", d), (d == 0) ? int'(busy0) : int'(busy1), eb);
            chk($sformatf("dut%0d done", d), (d == 0) ? int'(done0) : int'(done1), ed);
            chk($sformatf("dut%0d pass", d), (d == 0) ? int'(pass0) : int'(pass1), ep);
            chk($sformatf("dut%0d dut_a", d), (d == 0) ? int'(a0) : int'(a1), ea);
            chk($sformatf("dut%0d dut_b", d), (d == 0) ? int'(b0) : int'(b1), ebb);
            chk($sformatf("dut%0d err_count", d), (d == 0) ? int'(err0) : int'(err1), ee);
`ifdef COMP_BIST_FIRST_FAIL_EN
            ff = mact[d] ? first_fail(d) : -1;
            chk($sformatf("dut%0d fail_valid", d), (d == 0) ? int'(fv0) : int'(fv1), (ff >= 0) ? 1 : 0);
            chk($sformatf("dut%0d fail_a", d), (d == 0) ? int'(fa0) : int'(fa1), (ff >= 0) ? ff / 4 : 0);
            chk($sformatf("dut%0d fail_b", d), (d == 0) ? int'(fb0) : int'(fb1), (ff >= 0) ? ff % 4 : 0);
`else
            ff = 0;
`endif
        end
    end

    task automatic run(input int m0, input int m1, input bit noise,
                       output int busy_cyc0, output int done_at1);
        int cyc;
        @(negedge clk);
        mode0 = m0; mode1 = m1;
        start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        busy_cyc0 = 0; done_at1 = -1; cyc = 0;
        while (cyc < 300) begin
            if (busy0) busy_cyc0++;
            if (done1 && done_at1 < 0) done_at1 = cyc;
            if (!busy0 && !busy1 && cyc > 0) break;
            start0 = noise && !m_idle(0) && ($urandom_range(0, 2) == 0);
            start1 = noise && !m_idle(1) && ($urandom_range(0, 2) == 0);
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0; start1 = 1'b0;
        chk("sweep completes", int'(done0 && done1), 1);
    endtask

    initial begin
        int bc, d1;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy0), 0);
        chk("reset err", int'(err0), 0);
        chk("reset dut_a", int'(a0), 0);
        rst = 1'b0;

        run(0, 0, 1'b1, bc, d1);
        chk("ideal busy cycles", bc, 32);
        chk("settle3 done latency", d1, 64);
        chk("ideal err0", int'(err0), 0);
        chk("ideal pass0", int'(pass0), 1);
        chk("ideal pass1", int'(pass1), 1);
        chk("last vector a", int'(a0), 3);
        chk("last vector b", int'(b0), 3);

        run(1, 1, 1'b0, bc, d1);
        chk("aeb stuck err0", int'(err0), 4);
        chk("aeb stuck pass0", int'(pass0), 0);
        chk("aeb stuck err1 sat", int'(err1), 3);
`ifdef COMP_BIST_FIRST_FAIL_EN
        chk("first fail valid", int'(fv0), 1);
        chk("first fail a", int'(fa0), 0);
        chk("first fail b", int'(fb0), 0);
`endif

        run(2, 2, 1'b1, bc, d1);
        chk("swap err0", int'(err0), 12);
        chk("swap err1 saturates", int'(err1), 3);

        // Async reset at vector 7 of a faulty sweep.
        @(negedge clk);
        mode0 = 1; mode1 = 1;
        start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid sweep a", int'(a0), 1);
        chk("mid sweep b", int'(b0), 3);
        chk("mid sweep err", int'(err0), 2);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", int'(busy0), 0);
        chk("async rst err", int'(err0), 0);
        chk("async rst dut_a", int'(a0), 0);
        chk("async rst dut_b", int'(b0), 0);
        chk("async rst busy1", int'(busy1), 0);
        @(negedge clk);
        rst = 1'b0;

        run(0, 0, 1'b0, bc, d1);
        chk("fresh sweep busy cycles", bc, 32);
        chk("fresh sweep err", int'(err0), 0);

        repeat (3) run($urandom_range(0, 2), $urandom_range(0, 2), 1'b1, bc, d1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
